axis_pr_freeze_drain_bridge: RTL and testbench

Multi-channel AXI-S freeze bridge placed between the PR slot AFU and the static-region PCIe/HSSI streams. Freezes each stream at packet boundaries instead of cutting mid-packet. If the AFU stalls, the bridge synthesizes a poisoned terminating beat after a timeout. FIM-to-AFU traffic is discarded during freeze so the static region is never back-pressured. A single freeze_ack reports when all TX channels are quiesced, so PR control can sequence reconfiguration.

---
 rtl/axis_pr_freeze_drain_bridge.sv | 192 +++++++++++++++++++
 tb/tb_axis_pr_freeze_drain_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pr_freeze_drain_bridge.sv
// Multi-channel AXI-Stream freeze bridge for a PR slot: quiesces AFU TX at packet boundaries and
// discards FIM RX while frozen. Optional status counters are enabled by defining PR_FREEZE_STATS_EN.
module axis_pr_freeze_drain_bridge #(
  parameter int NUM_CH        = 2,
  parameter int TDATA_WIDTH   = 512,
  parameter int TUSER_WIDTH   = 10,
  parameter int POISON_BIT    = 0,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pr_freeze,
  output logic                            freeze_ack,
  input  logic [NUM_CH-1:0]               afu_tx_tvalid,
  output logic [NUM_CH-1:0]               afu_tx_tready,
  input  logic [NUM_CH-1:0]               afu_tx_tlast,
  input  logic [NUM_CH*TDATA_WIDTH-1:0]   afu_tx_tdata,
  input  logic [NUM_CH*TUSER_WIDTH-1:0]   afu_tx_tuser,
  output logic [NUM_CH-1:0]               fim_tx_tvalid,
  input  logic [NUM_CH-1:0]               fim_tx_tready,
  output logic [NUM_CH-1:0]               fim_tx_tlast,
  output logic [NUM_CH*TDATA_WIDTH-1:0]   fim_tx_tdata,
  output logic [NUM_CH*TUSER_WIDTH-1:0]   fim_tx_tuser,
  input  logic [NUM_CH-1:0]               fim_rx_tvalid,
  output logic [NUM_CH-1:0]               fim_rx_tready,
  input  logic [NUM_CH-1:0]               fim_rx_tlast,
  input  logic [NUM_CH*TDATA_WIDTH-1:0]   fim_rx_tdata,
  input  logic [NUM_CH*TUSER_WIDTH-1:0]   fim_rx_tuser,
  output logic [NUM_CH-1:0]               afu_rx_tvalid,
  input  logic [NUM_CH-1:0]               afu_rx_tready,
  output logic [NUM_CH-1:0]               afu_rx_tlast,
  output logic [NUM_CH*TDATA_WIDTH-1:0]   afu_rx_tdata,
  output logic [NUM_CH*TUSER_WIDTH-1:0]   afu_rx_tuser,
  output logic [NUM_CH*CNT_WIDTH-1:0]     tx_trunc_cnt,
  output logic [NUM_CH*CNT_WIDTH-1:0]     rx_drop_cnt,
  output logic [2*NUM_CH-1:0]             tx_state
);

  // Handshake: a beat transfers on a rising clk edge where tvalid & tready are both high;
  // tvalid never depends on tready, and a registered source holds its payload until it transfers.

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_TERM   = 2'd2;
  localparam logic [1:0] ST_FROZEN = 2'd3;

  localparam int TMR_W = $clog2(DRAIN_TIMEOUT);
  localparam logic [TMR_W-1:0]       TMR_LOAD    = TMR_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TUSER_WIDTH-1:0] POISON_USER = TUSER_WIDTH'(1) << POISON_BIT;

  logic [NUM_CH-1:0] ch_quiet;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) freeze_ack <= 1'b0;
    else        freeze_ack <= pr_freeze & (&ch_quiet);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [1:0]             state;
    logic [TMR_W-1:0]       timer;
    logic                   in_pkt;
    logic                   ovalid, olast;
    logic [TDATA_WIDTH-1:0] odata;
    logic [TUSER_WIDTH-1:0] ouser;
    logic out_free, tx_open, tx_acc, in_pkt_nxt, term_load;

    assign out_free         = ~ovalid | fim_tx_tready[c];
    assign tx_open          = (state == ST_RUN) | (state == ST_DRAIN);
    assign afu_tx_tready[c] = tx_open & out_free;
    assign tx_acc           = afu_tx_tvalid[c] & afu_tx_tready[c];
    assign in_pkt_nxt       = tx_acc ? ~afu_tx_tlast[c] : in_pkt;
    assign term_load        = (state == ST_TERM) & out_free;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovalid <= 1'b0;
        olast  <= 1'b0;
        odata  <= '0;
        ouser  <= '0;
      end else if (out_free) begin
        if (tx_acc) begin
          ovalid <= 1'b1;
          olast  <= afu_tx_tlast[c];
          odata  <= afu_tx_tdata[c*TDATA_WIDTH +: TDATA_WIDTH];
          ouser  <= afu_tx_tuser[c*TUSER_WIDTH +: TUSER_WIDTH];
        end else if (term_load) begin
          ovalid <= 1'b1;
          olast  <= 1'b1;
          odata  <= '0;
          ouser  <= POISON_USER;
        end else begin
          ovalid <= 1'b0;
        end
      end
    end

    // Freeze decisions use the post-acceptance packet state, so a tlast taken in the
    // same cycle as the request closes the packet cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= ST_RUN;
        timer  <= '0;
        in_pkt <= 1'b0;
      end else begin
        case (state)
          ST_RUN: begin
            in_pkt <= in_pkt_nxt;
            if (pr_freeze) begin
              if (in_pkt_nxt) begin
                state <= ST_DRAIN;
                timer <= TMR_LOAD;
              end else begin
                state <= ST_FROZEN;
              end
            end
          end
          ST_DRAIN: begin
            in_pkt <= in_pkt_nxt;
            if (tx_acc & afu_tx_tlast[c]) state <= ST_FROZEN;
            else if (timer == '0)         state <= ST_TERM;
            else                          timer <= timer - TMR_W'(1);
          end
          ST_TERM: begin
            if (out_free) begin
              state  <= ST_FROZEN;
              in_pkt <= 1'b0;
            end
          end
          default: begin
            if (!pr_freeze) begin
              state  <= ST_RUN;
              in_pkt <= 1'b0;
            end
          end
        endcase
      end
    end

    assign fim_tx_tvalid[c]                             = ovalid;
    assign fim_tx_tlast[c]                              = olast;
    assign fim_tx_tdata[c*TDATA_WIDTH +: TDATA_WIDTH]   = odata;
    assign fim_tx_tuser[c*TUSER_WIDTH +: TUSER_WIDTH]   = ouser;
    assign ch_quiet[c]                                  = (state == ST_FROZEN) & ~ovalid;
    assign tx_state[2*c +: 2]                           = state;

    // RX discard starts at once on freeze but only ends at a packet boundary.
    logic discard_q, rx_in_pkt, discard, rx_hs, rx_in_pkt_nxt;

    assign discard       = pr_freeze | discard_q;
    assign rx_hs         = fim_rx_tvalid[c] & fim_rx_tready[c];
    assign rx_in_pkt_nxt = rx_hs ? ~fim_rx_tlast[c] : rx_in_pkt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        discard_q <= 1'b0;
        rx_in_pkt <= 1'b0;
      end else begin
        discard_q <= pr_freeze | (discard_q & rx_in_pkt_nxt);
        rx_in_pkt <= rx_in_pkt_nxt;
      end
    end

    assign afu_rx_tvalid[c]                           = fim_rx_tvalid[c] & ~discard;
    assign fim_rx_tready[c]                           = discard | afu_rx_tready[c];
    assign afu_rx_tlast[c]                            = fim_rx_tlast[c];
    assign afu_rx_tdata[c*TDATA_WIDTH +: TDATA_WIDTH] = fim_rx_tdata[c*TDATA_WIDTH +: TDATA_WIDTH];
    assign afu_rx_tuser[c*TUSER_WIDTH +: TUSER_WIDTH] = fim_rx_tuser[c*TUSER_WIDTH +: TUSER_WIDTH];

`ifdef PR_FREEZE_STATS_EN
    logic [CNT_WIDTH-1:0] trunc_cnt, drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        trunc_cnt <= '0;
        drop_cnt  <= '0;
      end else begin
        if (term_load && !(&trunc_cnt)) trunc_cnt <= trunc_cnt + CNT_WIDTH'(1);
        if (discard && fim_rx_tvalid[c] && fim_rx_tlast[c] && !(&drop_cnt))
          drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      end
    end

    assign tx_trunc_cnt[c*CNT_WIDTH +: CNT_WIDTH] = trunc_cnt;
    assign rx_drop_cnt[c*CNT_WIDTH +: CNT_WIDTH]  = drop_cnt;
`else
    assign tx_trunc_cnt[c*CNT_WIDTH +: CNT_WIDTH] = '0;
    assign rx_drop_cnt[c*CNT_WIDTH +: CNT_WIDTH]  = '0;
`endif
  end

endmodule

// File: tb/tb_axis_pr_freeze_drain_bridge.sv
// Directed bench for axis_pr_freeze_drain_bridge: idle freeze, graceful drain, timeout,
// backpressured poison beat, RX discard across release, and reset during drain.
module tb_axis_pr_freeze_drain_bridge;

`ifdef PR_FREEZE_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  localparam int NC = 2, DW = 32, UW = 10, CW = 16, TO = 16;
  localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, TERM = 2'd2, FROZEN = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pr_freeze = 1'b0;
  logic freeze_ack;
  logic [NC-1:0]    afu_tx_tvalid = '0, afu_tx_tready, afu_tx_tlast = '0;
  logic [NC*DW-1:0] afu_tx_tdata = '0;
  logic [NC*UW-1:0] afu_tx_tuser = '0;
  logic [NC-1:0]    fim_tx_tvalid, fim_tx_tready = '1, fim_tx_tlast;
  logic [NC*DW-1:0] fim_tx_tdata;
  logic [NC*UW-1:0] fim_tx_tuser;
  logic [NC-1:0]    fim_rx_tvalid = '0, fim_rx_tready, fim_rx_tlast = '0;
  logic [NC*DW-1:0] fim_rx_tdata = '0;
  logic [NC*UW-1:0] fim_rx_tuser = '0;
  logic [NC-1:0]    afu_rx_tvalid, afu_rx_tready = '1, afu_rx_tlast;
  logic [NC*DW-1:0] afu_rx_tdata;
  logic [NC*UW-1:0] afu_rx_tuser;
  logic [NC*CW-1:0] tx_trunc_cnt, rx_drop_cnt;
  logic [2*NC-1:0]  tx_state;

  int checks = 0;
  int errors = 0;
  logic [43:0] exp_q[$];
  logic [43:0] obs_q[$];

  axis_pr_freeze_drain_bridge #(
    .NUM_CH(NC), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .POISON_BIT(0),
    .DRAIN_TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pr_freeze(pr_freeze), .freeze_ack(freeze_ack),
    .afu_tx_tvalid(afu_tx_tvalid), .afu_tx_tready(afu_tx_tready), .afu_tx_tlast(afu_tx_tlast),
    .afu_tx_tdata(afu_tx_tdata), .afu_tx_tuser(afu_tx_tuser),
    .fim_tx_tvalid(fim_tx_tvalid), .fim_tx_tready(fim_tx_tready), .fim_tx_tlast(fim_tx_tlast),
    .fim_tx_tdata(fim_tx_tdata), .fim_tx_tuser(fim_tx_tuser),
    .fim_rx_tvalid(fim_rx_tvalid), .fim_rx_tready(fim_rx_tready), .fim_rx_tlast(fim_rx_tlast),
    .fim_rx_tdata(fim_rx_tdata), .fim_rx_tuser(fim_rx_tuser),
    .afu_rx_tvalid(afu_rx_tvalid), .afu_rx_tready(afu_rx_tready), .afu_rx_tlast(afu_rx_tlast),
    .afu_rx_tdata(afu_rx_tdata), .afu_rx_tuser(afu_rx_tuser),
    .tx_trunc_cnt(tx_trunc_cnt), .rx_drop_cnt(rx_drop_cnt), .tx_state(tx_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // fim_tx monitor: captures every beat that will transfer at the coming rising edge
  always @(negedge clk) begin
    for (int c = 0; c < NC; c++)
      if (fim_tx_tvalid[c] && fim_tx_tready[c])
        obs_q.push_back({c[0], fim_tx_tlast[c], fim_tx_tuser[c*UW +: UW], fim_tx_tdata[c*DW +: DW]});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input int c, input logic [31:0] d, input logic l);
    logic acc;
    acc = 1'b0;
    afu_tx_tvalid[c] = 1'b1;
    afu_tx_tlast[c]  = l;
    afu_tx_tdata[c*DW +: DW] = d;
    afu_tx_tuser[c*UW +: UW] = 10'h002;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = afu_tx_tready[c];
      @(posedge clk);
      #1;
    end
    check("send_accept", {63'd0, acc}, 64'd1);
    afu_tx_tvalid[c] = 1'b0;
    exp_q.push_back({c[0], l, 10'h002, d});
  endtask

  task automatic compare_tx(input string tag);
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check(tag, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic rx_beat(input logic [31:0] d, input logic l, input logic deliver, input string tag);
    fim_rx_tvalid[0] = 1'b1;
    fim_rx_tlast[0]  = l;
    fim_rx_tdata[31:0] = d;
    fim_rx_tuser[9:0]  = 10'h155;
    #1;
    check({tag, "_avalid"}, {63'd0, afu_rx_tvalid[0]}, {63'd0, deliver});
    check({tag, "_fready"}, {63'd0, fim_rx_tready[0]}, 64'd1);
    if (deliver)
      check({tag, "_data"}, {21'd0, afu_rx_tlast[0], afu_rx_tuser[9:0], afu_rx_tdata[31:0]},
            {21'd0, l, 10'h155, d});
    @(posedge clk);
    #1;
    fim_rx_tvalid[0] = 1'b0;
  endtask

  initial begin
    // reset
    tick(3);
    check("rst_ack", {63'd0, freeze_ack}, 64'd0);
    check("rst_state", 64'(tx_state), 64'd0);
    check("rst_fim_tvalid", 64'(fim_tx_tvalid), 64'd0);
    check("rst_afu_rvalid", 64'(afu_rx_tvalid), 64'd0);
    check("rst_trunc", 64'(tx_trunc_cnt), 64'd0);
    check("rst_drop", 64'(rx_drop_cnt), 64'd0);
    rst_n = 1'b1;
    tick(6);

    // idle freeze
    pr_freeze = 1'b1;
    tick();
    check("idle_state", 64'(tx_state), 64'({FROZEN, FROZEN}));
    check("idle_ack_early", {63'd0, freeze_ack}, 64'd0);
    check("idle_tready", 64'(afu_tx_tready), 64'd0);
    tick();
    check("idle_ack", {63'd0, freeze_ack}, 64'd1);
    check("idle_trunc", 64'(tx_trunc_cnt), 64'd0);
    pr_freeze = 1'b0;
    tick();
    check("idle_release_ack", {63'd0, freeze_ack}, 64'd0);
    check("idle_release_state", 64'(tx_state), 64'({RUN, RUN}));
    tick(2);

    // graceful drain on ch0
    send_beat(0, 32'hA000_0001, 1'b0);
    send_beat(0, 32'hA000_0002, 1'b0);
    pr_freeze = 1'b1;
    tick();
    check("drain_state", 64'(tx_state), 64'({FROZEN, DRAIN}));
    send_beat(0, 32'hA000_0003, 1'b0);
    send_beat(0, 32'hA000_0004, 1'b1);
    check("drain_frozen", 64'(tx_state), 64'({FROZEN, FROZEN}));
    check("drain_ack_early", {63'd0, freeze_ack}, 64'd0);
    tick(2);
    check("drain_ack", {63'd0, freeze_ack}, 64'd1);
    check("drain_trunc", 64'(tx_trunc_cnt), 64'd0);
    compare_tx("drain_beats");
    pr_freeze = 1'b0;
    tick(2);

    // timeout on ch1
    send_beat(1, 32'hB000_0001, 1'b0);
    send_beat(1, 32'hB000_0002, 1'b0);
    pr_freeze = 1'b1;
    tick(TO);
    check("to_still_drain", 64'(tx_state), 64'({DRAIN, FROZEN}));
    tick();
    check("to_term", 64'(tx_state), 64'({TERM, FROZEN}));
    check("to_no_beat_yet", 64'(fim_tx_tvalid), 64'd0);
    tick();
    check("to_poison_valid", 64'(fim_tx_tvalid), 64'b10);
    check("to_poison_beat", {21'd0, fim_tx_tlast[1], fim_tx_tuser[19:10], fim_tx_tdata[63:32]},
          {21'd0, 1'b1, 10'h001, 32'h0});
    check("to_frozen", 64'(tx_state), 64'({FROZEN, FROZEN}));
    check("to_tready", 64'(afu_tx_tready), 64'd0);
    exp_q.push_back({1'b1, 1'b1, 10'h001, 32'h0});
    tick(2);
    check("to_ack", {63'd0, freeze_ack}, 64'd1);
    check("to_trunc", 64'(tx_trunc_cnt), 64'(STATS ? {16'd1, 16'd0} : 32'd0));
    compare_tx("to_beats");
    pr_freeze = 1'b0;
    tick(2);

    // backpressure while the poisoned beat is pending on ch0
    send_beat(0, 32'hC000_0001, 1'b0);
    tick();
    pr_freeze = 1'b1;
    fim_tx_tready[0] = 1'b0;
    tick(TO + 1);
    check("bp_term", 64'(tx_state), 64'({FROZEN, TERM}));
    tick();
    check("bp_poison_valid", 64'(fim_tx_tvalid), 64'b01);
    tick(3);
    check("bp_poison_hold", {21'd0, fim_tx_tlast[0], fim_tx_tuser[9:0], fim_tx_tdata[31:0]},
          {21'd0, 1'b1, 10'h001, 32'h0});
    check("bp_ack_held", {63'd0, freeze_ack}, 64'd0);
    exp_q.push_back({1'b0, 1'b1, 10'h001, 32'h0});
    fim_tx_tready[0] = 1'b1;
    tick();
    check("bp_ack_one", {63'd0, freeze_ack}, 64'd0);
    check("bp_drained", 64'(fim_tx_tvalid), 64'd0);
    tick();
    check("bp_ack_two", {63'd0, freeze_ack}, 64'd1);
    check("bp_trunc", 64'(tx_trunc_cnt), 64'(STATS ? {16'd1, 16'd1} : 32'd0));
    compare_tx("bp_beats");
    pr_freeze = 1'b0;
    tick(2);

    // RX discard spanning a release in the middle of packet 3
    for (int b = 0; b < 4; b++) rx_beat(32'h1100_0000 + b, b == 3, 1'b1, "rx_p1");
    pr_freeze = 1'b1;
    afu_rx_tready[0] = 1'b0;
    for (int b = 0; b < 4; b++) rx_beat(32'h2200_0000 + b, b == 3, 1'b0, "rx_p2");
    for (int b = 0; b < 4; b++) begin
      if (b == 2) pr_freeze = 1'b0;
      rx_beat(32'h3300_0000 + b, b == 3, 1'b0, "rx_p3");
    end
    afu_rx_tready[0] = 1'b1;
    rx_beat(32'h4400_0000, 1'b1, 1'b1, "rx_p4");
    check("rx_drop", 64'(rx_drop_cnt), 64'(STATS ? {16'd0, 16'd2} : 32'd0));
    tick(2);

    // reset while ch0 is draining
    send_beat(0, 32'hD000_0001, 1'b0);
    pr_freeze = 1'b1;
    tick(3);
    check("rstd_drain", 64'(tx_state), 64'({FROZEN, DRAIN}));
    rst_n = 1'b0;
    #1;
    check("rstd_state", 64'(tx_state), 64'd0);
    check("rstd_tvalid", 64'(fim_tx_tvalid), 64'd0);
    check("rstd_ack", {63'd0, freeze_ack}, 64'd0);
    check("rstd_trunc", 64'(tx_trunc_cnt), 64'd0);
    check("rstd_drop", 64'(rx_drop_cnt), 64'd0);
    tick(2);
    rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    tick(TO + 8);
    check("rstd_frozen", 64'(tx_state), 64'({FROZEN, FROZEN}));
    check("rstd_ack_after", {63'd0, freeze_ack}, 64'd1);
    check("rstd_trunc_after", 64'(tx_trunc_cnt), 64'd0);
    compare_tx("rstd_no_poison");
    pr_freeze = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
